mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 35 +++
 rtl/mem_arbiter.sv | 106 ++++++++++
 tb/tb_mem_arbiter.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the fetch/data requesters, the arbiter and the shared memory.
// The arbiter uses the slave modport; the environment uses master.
interface mem_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ack;
  logic [31:0] if_rdata;

  logic        d_req;
  logic        d_rd;
  logic        d_wr;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ack;
  logic [31:0] d_rdata;

  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_rd;
  logic        mem_wr;
  logic [31:0] mem_rdata;

  logic        busy;
  logic        owner;

  modport slave (
    input  if_req, if_addr, d_req, d_rd, d_wr, d_addr, d_wdata, mem_rdata,
    output if_ack, if_rdata, d_ack, d_rdata, mem_addr, mem_wdata, mem_rd, mem_wr, busy, owner
  );

  modport master (
    output if_req, if_addr, d_req, d_rd, d_wr, d_addr, d_wdata, mem_rdata,
    input  if_ack, if_rdata, d_ack, d_rdata, mem_addr, mem_wdata, mem_rd, mem_wr, busy, owner
  );
endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates one single-port memory between instruction fetch and data accesses.
// Data wins by default; fetch is forced through after STARVE_MAX consecutive losses.
module mem_arbiter #(
  parameter int unsigned STARVE_MAX = 4
) (
  input logic          clock,
  input logic          reset,
  mem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {StIdle, StCmd, StResp} state_e;

  localparam logic [3:0] StarveMax = 4'(STARVE_MAX);

  state_e      state_q;
  logic        owner_q;
  logic        rd_q;
  logic        if_ack_q;
  logic        d_ack_q;
  logic        mem_rd_q;
  logic        mem_wr_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_wdata_q;
  logic [31:0] if_rdata_q;
  logic [31:0] d_rdata_q;
  logic [3:0]  starve_q;

  logic if_valid;
  logic d_valid;
  logic grant_if;
  logic grant_d;

  // A requester being acked this cycle is not re-arbitrated until the next cycle.
  assign if_valid = bus.if_req & ~if_ack_q;
  assign d_valid  = bus.d_req & (bus.d_rd | bus.d_wr) & ~d_ack_q;
  assign grant_if = (state_q == StIdle) & if_valid & (~d_valid | (starve_q == StarveMax));
  assign grant_d  = (state_q == StIdle) & d_valid & ~grant_if;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StIdle;
      owner_q     <= 1'b0;
      rd_q        <= 1'b0;
      if_ack_q    <= 1'b0;
      d_ack_q     <= 1'b0;
      mem_rd_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      starve_q    <= '0;
    end else begin
      if_ack_q <= 1'b0;
      d_ack_q  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (grant_if) begin
            state_q    <= StCmd;
            owner_q    <= 1'b0;
            rd_q       <= 1'b1;
            mem_rd_q   <= 1'b1;
            mem_addr_q <= bus.if_addr;
            starve_q   <= '0;
          end else if (grant_d) begin
            state_q    <= StCmd;
            owner_q    <= 1'b1;
            // A simultaneous read+write strobe performs only the write.
            rd_q       <= ~bus.d_wr;
            mem_rd_q   <= ~bus.d_wr;
            mem_wr_q   <= bus.d_wr;
            mem_addr_q <= bus.d_addr;
            if (bus.d_wr) mem_wdata_q <= bus.d_wdata;
            if (bus.if_req && (starve_q != StarveMax)) starve_q <= starve_q + 4'd1;
          end
        end
        StCmd: begin
          state_q  <= StResp;
          mem_rd_q <= 1'b0;
          mem_wr_q <= 1'b0;
        end
        StResp: begin
          state_q <= StIdle;
          if (owner_q) begin
            d_ack_q <= 1'b1;
            if (rd_q) d_rdata_q <= bus.mem_rdata;
          end else begin
            if_ack_q <= 1'b1;
            if (rd_q) if_rdata_q <= bus.mem_rdata;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.if_ack    = if_ack_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_ack     = d_ack_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_rd    = mem_rd_q;
  assign bus.mem_wr    = mem_wr_q;
  assign bus.busy      = (state_q != StIdle);
  assign bus.owner     = owner_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction-level model checked every cycle, plus directed
// scenarios with literal expectations.
module tb_mem_arbiter;
  localparam int Starve = 2;

  logic clock;
  logic reset;
  mem_arbiter_if bus ();

  mem_arbiter #(.STARVE_MAX(Starve)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Shared memory: read data valid one cycle after mem_rd.
  logic [31:0] mem    [logic [31:0]];
  logic [31:0] shadow [logic [31:0]];

  always @(posedge clock) begin
    if (bus.mem_rd) bus.mem_rdata <= mem.exists(bus.mem_addr) ? mem[bus.mem_addr] : 32'h0;
    if (bus.mem_wr) mem[bus.mem_addr] = bus.mem_wdata;
  end

  function automatic logic [31:0] shadow_rd(input logic [31:0] a);
    return shadow.exists(a) ? shadow[a] : 32'h0;
  endfunction

  task automatic preload(input logic [31:0] a, input logic [31:0] d);
    mem[a]    = d;
    shadow[a] = d;
  endtask

  // Model: an access is granted, then runs a fixed 3-cycle life (cmd, resp, ack).
  int          m_phase;
  logic        m_owner, m_read;
  logic [31:0] m_addr, m_wdata, m_data;
  int          m_cnt;
  logic        e_rd, e_wr, e_if_ack, e_d_ack;
  logic [31:0] e_if_rdata, e_d_rdata;
  bit          chk_en = 0;
  bit          log_en = 0;
  int          mdl_g[$];
  int          dut_g[$];

  always @(negedge clock) begin
    logic ifv, dv, take_if;
    if (chk_en) begin
      check("busy", bus.busy, m_phase != 0);
      check("mem_rd", bus.mem_rd, e_rd);
      check("mem_wr", bus.mem_wr, e_wr);
      check("mem_addr", bus.mem_addr, m_addr);
      check("mem_wdata", bus.mem_wdata, m_wdata);
      check("if_ack", bus.if_ack, e_if_ack);
      check("d_ack", bus.d_ack, e_d_ack);
      check("if_rdata", bus.if_rdata, e_if_rdata);
      check("d_rdata", bus.d_rdata, e_d_rdata);
      if (m_phase != 0) check("owner", bus.owner, m_owner);
    end
    if (reset) begin
      m_phase = 0; m_owner = 0; m_read = 0; m_addr = 0; m_wdata = 0; m_data = 0; m_cnt = 0;
      e_rd = 0; e_wr = 0; e_if_ack = 0; e_d_ack = 0; e_if_rdata = 0; e_d_rdata = 0;
    end else begin
      ifv = bus.if_req && !e_if_ack;
      dv  = bus.d_req && (bus.d_rd || bus.d_wr) && !e_d_ack;
      e_if_ack = 0;
      e_d_ack  = 0;
      if (m_phase == 0) begin
        if (ifv || dv) begin
          take_if = ifv && (!dv || m_cnt == Starve);
          m_phase = 1;
          m_owner = !take_if;
          if (take_if) begin
            m_addr = bus.if_addr; m_read = 1; m_data = shadow_rd(m_addr); m_cnt = 0;
          end else begin
            m_addr = bus.d_addr;
            m_read = !bus.d_wr;
            if (bus.d_wr) begin
              m_wdata = bus.d_wdata;
              shadow[m_addr] = m_wdata;
            end else m_data = shadow_rd(m_addr);
            if (bus.if_req && m_cnt < Starve) m_cnt++;
          end
          e_rd = m_read;
          e_wr = !m_read;
          if (log_en) mdl_g.push_back(int'(m_owner));
        end
      end else if (m_phase == 1) begin
        m_phase = 2; e_rd = 0; e_wr = 0;
      end else begin
        m_phase = 0;
        if (m_owner) begin
          e_d_ack = 1;
          if (m_read) e_d_rdata = m_data;
        end else begin
          e_if_ack = 1;
          if (m_read) e_if_rdata = m_data;
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    bus.if_req = 0; bus.if_addr = 0;
    bus.d_req = 0; bus.d_rd = 0; bus.d_wr = 0; bus.d_addr = 0; bus.d_wdata = 0;
  endtask

  task automatic do_reset();
    reset = 1;
    cyc();
    cyc();
    reset = 0;
  endtask

  int exp_g[6] = '{1, 1, 0, 1, 1, 0};

  initial begin
    idle_inputs();
    preload(32'h10, 32'hDEADBEEF);
    preload(32'h14, 32'h12345678);
    do_reset();
    chk_en = 1;
    check("rst_busy", bus.busy, 0);
    check("rst_d_rdata", bus.d_rdata, 0);
    check("rst_mem_addr", bus.mem_addr, 0);

    // Plain fetch; if_req held through the ack cycle must not re-grant.
    cyc();
    bus.if_req = 1; bus.if_addr = 32'h10;
    cyc();
    check("if_c1_mem_rd", bus.mem_rd, 1);
    check("if_c1_addr", bus.mem_addr, 32'h10);
    cyc();
    cyc();
    check("if_c3_ack", bus.if_ack, 1);
    check("if_c3_rdata", bus.if_rdata, 32'hDEADBEEF);
    cyc();
    check("if_c4_busy", bus.busy, 0);
    check("if_c4_ack", bus.if_ack, 0);
    idle_inputs();
    cyc();

    // Collision: data write first, fetch granted in the data ack cycle.
    bus.if_req = 1; bus.if_addr = 32'h14;
    bus.d_req = 1; bus.d_wr = 1; bus.d_addr = 32'h20; bus.d_wdata = 32'h55;
    cyc();
    check("col_c1_wr", bus.mem_wr, 1);
    check("col_c1_rd", bus.mem_rd, 0);
    check("col_c1_addr", bus.mem_addr, 32'h20);
    check("col_c1_wdata", bus.mem_wdata, 32'h55);
    cyc();
    cyc();
    check("col_c3_d_ack", bus.d_ack, 1);
    bus.d_req = 0; bus.d_wr = 0;
    cyc();
    check("col_c4_rd", bus.mem_rd, 1);
    check("col_c4_addr", bus.mem_addr, 32'h14);
    cyc();
    cyc();
    check("col_c6_if_ack", bus.if_ack, 1);
    check("col_c6_rdata", bus.if_rdata, 32'h12345678);
    idle_inputs();
    cyc();

    // Data read of the written word, then read+write to 0x40.
    bus.d_req = 1; bus.d_rd = 1; bus.d_addr = 32'h20;
    cyc();
    cyc();
    cyc();
    check("dr_ack", bus.d_ack, 1);
    check("dr_rdata", bus.d_rdata, 32'h55);
    idle_inputs();
    cyc();
    bus.d_req = 1; bus.d_rd = 1; bus.d_wr = 1; bus.d_addr = 32'h40; bus.d_wdata = 32'hA5A5A5A5;
    cyc();
    check("rw_c1_wr", bus.mem_wr, 1);
    check("rw_c1_rd", bus.mem_rd, 0);
    cyc();
    cyc();
    check("rw_c3_ack", bus.d_ack, 1);
    check("rw_c3_rdata", bus.d_rdata, 32'h55);
    idle_inputs();
    bus.if_req = 1; bus.if_addr = 32'h40;
    cyc();
    cyc();
    cyc();
    check("rw_fetch_rdata", bus.if_rdata, 32'hA5A5A5A5);
    idle_inputs();
    cyc();

    // Reset during the command cycle of a data read aborts it.
    bus.d_req = 1; bus.d_rd = 1; bus.d_addr = 32'h14;
    cyc();
    check("ab_c1_rd", bus.mem_rd, 1);
    reset = 1;
    cyc();
    reset = 0;
    check("ab_c2_rd", bus.mem_rd, 0);
    check("ab_c2_busy", bus.busy, 0);
    check("ab_c2_ack", bus.d_ack, 0);
    check("ab_c2_rdata", bus.d_rdata, 0);
    cyc();
    check("ab_c3_regrant", bus.mem_rd, 1);
    cyc();
    cyc();
    check("ab_c5_ack", bus.d_ack, 1);
    check("ab_c5_rdata", bus.d_rdata, 32'h12345678);
    idle_inputs();
    cyc();

    // Starvation: data re-presented continuously; fetch withdraws during data acks.
    do_reset();
    preload(32'h80, 32'h0000_0080);
    preload(32'h84, 32'h0000_0084);
    log_en = 1;
    bus.d_req = 1; bus.d_rd = 1; bus.d_addr = 32'h80; bus.if_addr = 32'h84; bus.if_req = 1;
    for (int i = 0; i < 60 && dut_g.size() < 6; i++) begin
      cyc();
      if (bus.mem_rd || bus.mem_wr) dut_g.push_back(int'(bus.owner));
      bus.if_req = !bus.d_ack;
    end
    log_en = 0;
    check("starve_grants", dut_g.size(), 6);
    check("starve_model_grants", mdl_g.size() >= 6, 1);
    if (dut_g.size() >= 6 && mdl_g.size() >= 6) begin
      for (int i = 0; i < 6; i++) begin
        check($sformatf("starve_dut[%0d]", i), dut_g[i], exp_g[i]);
        check($sformatf("starve_model[%0d]", i), mdl_g[i], exp_g[i]);
      end
    end
    idle_inputs();
    repeat (4) cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
